// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, with bounded bursts.
// Optional FIFO_ARB_STALL_CNT_EN adds a saturating full-stall counter (stall_cnt, stall_clr).
//
// state   | meaning
// IDLE    | no owner, waiting for any request
// BURST   | owner granted, words accepted while FIFO has room
// HOLD    | owner still requesting but FIFO full; grant frozen
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 32,
   parameter int BURST_MAX = 4,
   localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               wclk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ack,
   input  logic               fifo_full,
   output logic               fifo_wr_en,
   output logic [DW-1:0]      fifo_wr_data,
   output logic [IW-1:0]      grant_id,
   output logic               busy
`ifdef FIFO_ARB_STALL_CNT_EN
   ,
   input  logic               stall_clr,
   output logic [15:0]        stall_cnt
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BURST = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]      state, state_nxt;
   logic [NREQ-1:0] grant, grant_nxt;
   logic [3:0]      burst_cnt, cnt_nxt;
   logic [IW-1:0]   rr_ptr, ptr_nxt;
   logic [IW-1:0]   owner, winner, win_hi, win_lo;
   logic            hi_found;
   logic [NREQ-1:0] win_onehot;
   logic            any_req, own_req, acked, release_now;

   assign req_ack    = grant & req & {NREQ{~fifo_full}};
   assign fifo_wr_en = |req_ack;
   assign any_req    = |req;
   assign own_req    = |(grant & req);
   assign acked      = fifo_wr_en;
   assign busy       = (state != S_IDLE);
   assign grant_id   = owner;

   always_comb begin
      owner        = '0;
      fifo_wr_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            owner        = IW'(i);
            fifo_wr_data = req_data[i*DW +: DW];
         end
      end
   end

   // Lowest requester above rr_ptr wins; otherwise wrap to the lowest overall,
   // which leaves the last owner at the lowest priority.
   always_comb begin
      win_hi   = '0;
      win_lo   = '0;
      hi_found = 1'b0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req[i]) begin
            win_lo = IW'(i);
            if (IW'(i) > rr_ptr) begin
               win_hi   = IW'(i);
               hi_found = 1'b1;
            end
         end
      end
      winner     = hi_found ? win_hi : win_lo;
      win_onehot = NREQ'(1) << winner;
   end

   assign release_now = ~own_req | (acked & (burst_cnt == 4'(BURST_MAX - 1)));

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      cnt_nxt   = burst_cnt;
      ptr_nxt   = rr_ptr;
      case (state)
         S_IDLE: begin
            if (any_req) begin
               grant_nxt = win_onehot;
               ptr_nxt   = winner;
               cnt_nxt   = '0;
               state_nxt = S_BURST;
            end
         end
         S_BURST, S_HOLD: begin
            if (fifo_full && own_req) begin
               state_nxt = S_HOLD;
            end else begin
               state_nxt = S_BURST;
               if (acked) cnt_nxt = burst_cnt + 4'd1;
               if (release_now) begin
                  if (any_req) begin
                     grant_nxt = win_onehot;
                     ptr_nxt   = winner;
                     cnt_nxt   = '0;
                  end else begin
                     grant_nxt = '0;
                     cnt_nxt   = '0;
                     state_nxt = S_IDLE;
                  end
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            grant_nxt = '0;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         grant     <= '0;
         burst_cnt <= '0;
         rr_ptr    <= IW'(NREQ - 1);
      end else begin
         state     <= state_nxt;
         grant     <= grant_nxt;
         burst_cnt <= cnt_nxt;
         rr_ptr    <= ptr_nxt;
      end
   end

`ifdef FIFO_ARB_STALL_CNT_EN
   always_ff @(posedge wclk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_clr) begin
         stall_cnt <= '0;
      end else if (fifo_full && any_req && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus randomized traffic.
module tb_fifo_wr_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int BM   = 4;

   logic               wclk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ack;
   logic               fifo_full;
   logic               fifo_wr_en;
   logic [DW-1:0]      fifo_wr_data;
   logic [1:0]         grant_id;
   logic               busy;
`ifdef FIFO_ARB_STALL_CNT_EN
   logic               stall_clr;
   logic [15:0]        stall_cnt;
`endif

   fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BM)) dut (
      .wclk(wclk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
      .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
      .grant_id(grant_id), .busy(busy)
`ifdef FIFO_ARB_STALL_CNT_EN
      , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
   );

   always #5 wclk = ~wclk;

   typedef struct {int cyc; int id; logic [DW-1:0] data;} exp_t;
   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // reference model: owner (-1 = none), words taken this grant, last owner
   int m_owner, m_cnt, m_ptr;
   int unsigned m_stall;
   int words_left[NREQ];
   logic [DW-1:0] cur_data[NREQ];
   int fair_log[$];
   bit fair_on = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic int rr_win(input logic [NREQ-1:0] r, input int p);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic apply_inputs();
      for (int i = 0; i < NREQ; i++) begin
         req[i] = (words_left[i] > 0);
         req_data[i*DW +: DW] = cur_data[i];
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_cnt   = 0;
      m_ptr   = NREQ - 1;
      m_stall = 0;
      for (int i = 0; i < NREQ; i++) words_left[i] = 0;
   endtask

   // One clock cycle: called at posedge+1 with this cycle's inputs applied.
   task automatic cycle();
      logic [NREQ-1:0] r;
      int ack_id;
      bit rel;
      cyc++;
      r = req;
      chk("grant_id", 64'(grant_id), 64'((m_owner < 0) ? 0 : m_owner));
      chk("busy", 64'(busy), 64'(m_owner >= 0));
`ifdef FIFO_ARB_STALL_CNT_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      if (stall_clr) m_stall = 0;
      else if (fifo_full && r != 0 && m_stall < 32'hFFFF) m_stall++;
`endif
      ack_id = (m_owner >= 0 && r[m_owner] && !fifo_full) ? m_owner : -1;
      if (ack_id >= 0) sb.push_back('{cyc, ack_id, cur_data[ack_id]});
      if (m_owner < 0) begin
         if (r != 0) begin
            m_owner = rr_win(r, m_ptr);
            m_ptr = m_owner;
            m_cnt = 0;
         end
      end else if (!(fifo_full && r[m_owner])) begin
         rel = !r[m_owner] || (ack_id >= 0 && m_cnt == BM - 1);
         if (ack_id >= 0) m_cnt++;
         if (rel) begin
            if (r != 0) begin
               m_owner = rr_win(r, m_ptr);
               m_ptr = m_owner;
            end else begin
               m_owner = -1;
            end
            m_cnt = 0;
         end
      end
      if (ack_id >= 0) begin
         words_left[ack_id]--;
         cur_data[ack_id] = $urandom;
      end
      @(posedge wclk); #1;
      apply_inputs();
   endtask

   // Asserts rst mid-cycle with random requests and checks outputs clear at once.
   task automatic do_reset();
      rst = 1'b1;
      req = NREQ'($urandom);
      fifo_full = 1'b0;
      #1;
      chk("rst_ack", 64'(req_ack), 0);
      chk("rst_wr_en", 64'(fifo_wr_en), 0);
      chk("rst_wr_data", 64'(fifo_wr_data), 0);
      chk("rst_grant_id", 64'(grant_id), 0);
      chk("rst_busy", 64'(busy), 0);
`ifdef FIFO_ARB_STALL_CNT_EN
      chk("rst_stall", 64'(stall_cnt), 0);
`endif
      model_reset();
      sb.delete();
      @(posedge wclk); #1;
      @(posedge wclk); #1;
      rst = 1'b0;
   endtask

   task automatic run_until_idle(input int maxc, input bit rnd_full);
      bit done;
      done = 1'b0;
      for (int n = 0; n < maxc && !done; n++) begin
         fifo_full = rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0;
         cycle();
         done = (m_owner < 0);
         for (int i = 0; i < NREQ; i++) if (words_left[i] > 0) done = 1'b0;
      end
      fifo_full = 1'b0;
      chk("drain_done", 64'(done), 1);
      chk("sb_drained", 64'(sb.size()), 0);
   endtask

   always @(negedge wclk) begin
      exp_t e;
      if (rst === 1'b0) begin
         if (fifo_wr_en === 1'b1) begin
            chk("wr_while_full", 64'(fifo_full), 0);
            chk("write_expected", 64'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("ack_cycle", 64'(cyc), 64'(e.cyc));
               chk("ack_vec", 64'(req_ack), 64'(1) << e.id);
               chk("wr_data", 64'(fifo_wr_data), 64'(e.data));
            end
            if (fair_on) begin
               for (int i = 0; i < NREQ; i++) if (req_ack[i]) fair_log.push_back(i);
            end
         end else begin
            chk("ack_idle", 64'(req_ack), 0);
         end
      end
   end

   initial begin
      rst = 1'b1;
      fifo_full = 1'b0;
      req = '0;
      req_data = '0;
`ifdef FIFO_ARB_STALL_CNT_EN
      stall_clr = 1'b0;
`endif
      for (int i = 0; i < NREQ; i++) cur_data[i] = $urandom;
      model_reset();
      @(posedge wclk); #1;

      // single requester, 6 words across a burst boundary
      do_reset();
      words_left[2] = 6;
      apply_inputs();
      run_until_idle(40, 1'b0);

      // fairness: all four requesting from reset
      do_reset();
      for (int i = 0; i < NREQ; i++) words_left[i] = 8;
      apply_inputs();
      fair_log.delete();
      fair_on = 1'b1;
      run_until_idle(60, 1'b0);
      fair_on = 1'b0;
      chk("fair_len", 64'(fair_log.size()), 32);
      for (int k = 0; k < 20 && k < fair_log.size(); k++)
         chk("fair_owner", 64'(fair_log[k]), 64'((k / 4) % 4));

      // backpressure: 5 full cycles after requester 1's second ack
      do_reset();
      words_left[1] = 6;
      words_left[2] = 3;
      apply_inputs();
      begin
         int fcnt;
         bit started;
         fcnt = 0;
         started = 1'b0;
         for (int n = 0; n < 40 && (words_left[1] > 0 || words_left[2] > 0 || m_owner >= 0); n++) begin
            fifo_full = (fcnt > 0);
            cycle();
            if (fcnt > 0) fcnt--;
            if (!started && words_left[1] == 4) begin
               started = 1'b1;
               fcnt = 5;
            end
         end
         fifo_full = 1'b0;
         chk("bp_started", 64'(started), 1);
         chk("bp_drained", 64'(sb.size()), 0);
`ifdef FIFO_ARB_STALL_CNT_EN
         chk("bp_stall_cnt", 64'(stall_cnt), 5);
`endif
      end

      // early release: 0 stops after 2 words while 3 waits
      do_reset();
      words_left[0] = 2;
      words_left[3] = 3;
      apply_inputs();
      run_until_idle(30, 1'b0);

      // reset mid-burst, then 1 and 3 together
      do_reset();
      words_left[0] = 10;
      apply_inputs();
      for (int n = 0; n < 3; n++) cycle();
      do_reset();
      words_left[1] = 2;
      words_left[3] = 2;
      apply_inputs();
      run_until_idle(30, 1'b0);

      // randomized traffic with random backpressure
      do_reset();
      apply_inputs();
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NREQ; i++)
            if (words_left[i] == 0 && $urandom_range(0, 7) == 0) words_left[i] = $urandom_range(1, 9);
         apply_inputs();
         fifo_full = ($urandom_range(0, 3) == 0);
`ifdef FIFO_ARB_STALL_CNT_EN
         stall_clr = ($urandom_range(0, 31) == 0);
`endif
         cycle();
      end
`ifdef FIFO_ARB_STALL_CNT_EN
      stall_clr = 1'b0;
`endif
      run_until_idle(400, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the write port of the 32-bit async FIFO among NREQ producers in the write clock domain.
- Grants one requester at a time, with bounded bursts.
- Drives fifo_wr_en and fifo_wr_data directly and honours fifo_full so no write is ever dropped.
- Sits between producer blocks and the FIFO write side; the FIFO's own fifo_wr_err must never fire.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 32, data width; matches the FIFO word width.
- BURST_MAX, 4, maximum accepted writes per grant before rotation (1..15).

Ports:
- wclk  input  1  write-domain clock; single clock for the block.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NREQ  per-requester write request; held until acked.
- req_data  input  NREQ*DW  packed data; slice i = req_data[i*DW +: DW]; stable while req[i] is high and not yet acked.
- req_ack  output  NREQ  one-hot; word from requester i accepted this cycle.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_wr_data  output  DW  FIFO write data.
- grant_id  output  clog2(NREQ)  index of the current owner; 0 when idle.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Registered state: state {IDLE, BURST, HOLD}, one-hot grant[NREQ-1:0], burst_cnt (4 bit), rr_ptr (last owner).
- Reset (async, rst=1): state=IDLE, grant=0, burst_cnt=0, rr_ptr=NREQ-1, so requester 0 wins first.
  - Because the outputs are combinational from grant, req_ack=0, fifo_wr_en=0 and fifo_wr_data=0 immediately, and grant_id=0, busy=0.
- Combinational outputs:
  - req_ack[i] = grant[i] & req[i] & ~fifo_full.
  - fifo_wr_en = |req_ack.
  - fifo_wr_data = slice of the granted requester when grant≠0, else 0.
- RR winner: the first i with req[i]=1, searching from rr_ptr+1 upward with wrap modulo NREQ.
- IDLE: if any req, then at the next edge grant<=winner, rr_ptr<=winner, burst_cnt<=0, state<=BURST.
  - Latency from req to first ack is 1 cycle, given fifo_full=0.
- BURST, owner o:
  - On ack: burst_cnt++.
  - Release when ack occurs with burst_cnt==BURST_MAX-1, or when req[o]=0.
  - On release: if any other req is pending, grant<=next RR winner (search excludes nobody; o is last priority), burst_cnt<=0, stay in BURST with no bubble cycle.
  - If only o is still requesting, re-grant o with burst_cnt<=0 and no bubble.
  - If nothing is pending, grant<=0 and state<=IDLE.
  - fifo_full=1 with req[o]=1: state<=HOLD; grant and burst_cnt unchanged.
- HOLD:
  - No acks.
  - fifo_full=0: back to BURST.
  - req[o] drops: release as above.
  - Grant does not rotate while the FIFO is full.
- Simultaneous ack and release on the same edge: the accepted word counts; the new owner may be acked on the next cycle.
- Invariants:
  - At most one req_ack bit is high per cycle.
  - fifo_wr_en is never high while fifo_full=1.
  - A requester waits at most (NREQ-1)*BURST_MAX accepted writes plus FIFO-full cycles.

Optional Feature:
- Macro FIFO_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0]: a saturating count (stops at 16'hFFFF) of cycles with fifo_full=1 and |req=1.
  - Cleared by rst.
  - Adds input stall_clr (1 bit), which synchronously zeroes the counter; stall_clr has priority over increment.
- Undefined: the port, input and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 during random req -> req_ack=0, fifo_wr_en=0, fifo_wr_data=0, grant_id=0, busy=0, asynchronously and without waiting for an edge.
- Single requester: req[2]=1 for 6 words, BURST_MAX=4, fifo_full=0 -> grant_id=2 one cycle after req; 6 acks on 6 consecutive cycles; no bubble at the burst boundary; busy falls after the last ack.
- Fairness: req=4'hF held from reset -> ack owner sequence 0×4, 1×4, 2×4, 3×4, 0×4; fifo_wr_en high every cycle after the first.
- Backpressure: fifo_full=1 for 5 cycles after requester 1's second ack -> state HOLD; no acks and fifo_wr_en=0 for 5 cycles; grant_id stays 1; burst resumes with exactly 2 more words before rotation.
- Early release: requester 0 drops req after 2 acks while req[3]=1 -> grant_id=3 on the next cycle; first ack to 3 in that cycle.
- Reset mid-burst, then req[1] and req[3] together -> after rst falls, requester 1 granted first; with FIFO_ARB_STALL_CNT_EN, stall_cnt=0 after reset and equals 5 after the backpressure scenario.
